// File: rtl/mul_hilo_ctrl_if.sv
// Request channel from EX into the HI/LO issue/writeback controller.
// The master drives an operation and its operands; the slave answers with ready.
interface mul_hilo_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;

  modport master (output req_valid, req_op, req_src1, req_src2, input req_ready);
  modport slave  (input req_valid, req_op, req_src1, req_src2, output req_ready);
endinterface

// File: rtl/mul_hilo_ctrl.sv
// HI/LO issue and writeback controller for the pipelined 32x32 multiplier.
// Define MUL_ACC_EN to make ops 1xx accumulate/subtract; otherwise they are accepted as no-ops.
module mul_hilo_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                   mul_clk,
  input  logic                   reset,
  mul_hilo_ctrl_if.slave         req,
  input  logic                   flush,
  output logic [31:0]            mul_x,
  output logic [31:0]            mul_y,
  output logic                   mul_signed,
  input  logic [63:0]            mul_result,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic                   hilo_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        accept;
  logic [63:0] wb_value;

`ifdef MUL_ACC_EN
  // op_q = {accumulate, subtract}; MULT/MULTU latch 2'b00 and write the raw product.
  logic [1:0]  op_q, op_d;
  logic [63:0] hilo_cur;

  always_comb begin
    hilo_cur = {hi_q, lo_q};
    wb_value = mul_result;
    if (op_q[1]) wb_value = op_q[0] ? (hilo_cur - mul_result) : (hilo_cur + mul_result);
  end
`else
  assign wb_value = mul_result;
`endif

  assign req.req_ready = (state_q == S_IDLE) && !reset;
  assign accept        = req.req_valid && req.req_ready && !flush;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MUL_ACC_EN
    op_d    = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req.req_op)
            OP_MTHI: hi_d = req.req_src1;
            OP_MTLO: lo_d = req.req_src1;
            OP_MULT, OP_MULTU: begin
              x_d     = req.req_src1;
              y_d     = req.req_src2;
              sgn_d   = ~req.req_op[0];
              cnt_d   = CNT_INIT;
              state_d = S_CALC;
`ifdef MUL_ACC_EN
              op_d    = 2'b00;
`endif
            end
            default: begin
`ifdef MUL_ACC_EN
              x_d     = req.req_src1;
              y_d     = req.req_src2;
              sgn_d   = ~req.req_op[0];
              cnt_d   = CNT_INIT;
              state_d = S_CALC;
              op_d    = {1'b1, req.req_op[1]};
`endif
            end
          endcase
        end
      end
      S_CALC: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == 3'd0) state_d = S_WB;
        else                    cnt_d   = cnt_q - 3'd1;
      end
      S_WB: begin
        // A flush landing in the writeback cycle still cancels the write.
        state_d = S_IDLE;
        if (!flush) {hi_d, lo_d} = wb_value;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked block and not in the sensitivity list.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MUL_ACC_EN
      op_q    <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MUL_ACC_EN
      op_q    <= op_d;
`endif
    end
  end

  assign mul_x      = x_q;
  assign mul_y      = y_q;
  assign mul_signed = sgn_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign hilo_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: one instance at MUL_LAT=1, one at MUL_LAT=3,
// each fed by a behavioural multiplier; expected HI/LO values are hand-computed constants.
module tb_mul_hilo_ctrl;

  logic        mul_clk = 1'b0;
  logic        reset;
  logic        flush;
  int          vectors    = 0;
  int          miscompares = 0;

  logic [31:0] x1, y1, hi1, lo1, x3, y3, hi3, lo3;
  logic        s1, s3, busy1, busy3;
  logic [63:0] r1, r3;

  mul_hilo_ctrl_if if1 ();
  mul_hilo_ctrl_if if3 ();

  always #5 mul_clk = ~mul_clk;

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  assign r1 = mul_model(x1, y1, s1);
  assign r3 = mul_model(x3, y3, s3);

  mul_hilo_ctrl #(.MUL_LAT(1)) u_dut1 (
    .mul_clk(mul_clk), .reset(reset), .req(if1), .flush(flush),
    .mul_x(x1), .mul_y(y1), .mul_signed(s1), .mul_result(r1),
    .hi(hi1), .lo(lo1), .hilo_busy(busy1));

  mul_hilo_ctrl #(.MUL_LAT(3)) u_dut3 (
    .mul_clk(mul_clk), .reset(reset), .req(if3), .flush(flush),
    .mul_x(x3), .mul_y(y3), .mul_signed(s3), .mul_result(r3),
    .hi(hi3), .lo(lo3), .hilo_busy(busy3));

  task automatic tick();
    @(posedge mul_clk);
    #1;
  endtask

  // Present one request to the LAT=1 instance, take the accept edge, then drop valid.
  task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if1.req_valid = 1'b1;
    if1.req_op    = op;
    if1.req_src1  = a;
    if1.req_src2  = b;
    tick();
    if1.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    vectors++; if (if1.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", if1.req_ready); end
    vectors++; if ({hi1, lo1} !== 64'd0) begin miscompares++; $display("FAIL reset_hilo: got %h want 0", {hi1, lo1}); end
    vectors++; if ({x1, y1, s1, busy1} !== 66'd0) begin miscompares++; $display("FAIL reset_ops: got %h want 0", {x1, y1, s1, busy1}); end
    reset = 1'b0;
    #1;
    vectors++; if (if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", if1.req_ready); end
  endtask

  task automatic test_mthi_mtlo();
    issue1(3'b010, 32'h12345678, 32'h0);
    vectors++; if (hi1 !== 32'h12345678) begin miscompares++; $display("FAIL mthi: hi=%h want 12345678", hi1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL mthi_busy: got %b want 0", busy1); end
    issue1(3'b011, 32'h9ABCDEF0, 32'h0);
    vectors++; if ({hi1, lo1} !== 64'h12345678_9ABCDEF0) begin miscompares++; $display("FAIL mtlo: hilo=%h want 123456789abcdef0", {hi1, lo1}); end
    vectors++; if (busy1 !== 1'b0 || if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL mtlo_idle: busy=%b ready=%b want 0 1", busy1, if1.req_ready); end
  endtask

  task automatic test_mult_signed();
    issue1(3'b000, 32'hFFFFFFFD, 32'd5);
    vectors++; if (s1 !== 1'b1 || x1 !== 32'hFFFFFFFD || y1 !== 32'd5) begin miscompares++; $display("FAIL mult_operands: s=%b x=%h y=%h", s1, x1, y1); end
    vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL mult_busy1: got %b want 1", busy1); end
    tick();
    vectors++; if (busy1 !== 1'b1 || hi1 !== 32'h12345678) begin miscompares++; $display("FAIL mult_busy2: busy=%b hi=%h want 1 12345678", busy1, hi1); end
    tick();
    vectors++; if ({hi1, lo1} !== 64'hFFFFFFFF_FFFFFFF1) begin miscompares++; $display("FAIL mult_result: got %h want fffffffffffffff1", {hi1, lo1}); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL mult_done: busy=%b want 0", busy1); end
  endtask

  task automatic test_multu();
    issue1(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    vectors++; if (s1 !== 1'b0 || if1.req_ready !== 1'b0) begin miscompares++; $display("FAIL multu_calc: s=%b ready=%b want 0 0", s1, if1.req_ready); end
    tick();
    vectors++; if (if1.req_ready !== 1'b0) begin miscompares++; $display("FAIL multu_wb_ready: got %b want 0", if1.req_ready); end
    tick();
    vectors++; if ({hi1, lo1} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL multu_result: got %h want fffffffe00000001", {hi1, lo1}); end
    vectors++; if (if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL multu_ready: got %b want 1", if1.req_ready); end
  endtask

  task automatic test_flush();
    issue1(3'b000, 32'd7, 32'd6);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if ({hi1, lo1} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL flush_wb: got %h want fffffffe00000001", {hi1, lo1}); end
    vectors++; if (busy1 !== 1'b0 || if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_idle: busy=%b ready=%b want 0 1", busy1, if1.req_ready); end
    issue1(3'b000, 32'd2, 32'd3);
    tick();
    tick();
    vectors++; if ({hi1, lo1} !== 64'd6) begin miscompares++; $display("FAIL after_flush: got %h want 6", {hi1, lo1}); end
    // Flush beats a simultaneous request in IDLE.
    flush = 1'b1;
    issue1(3'b010, 32'hDEADBEEF, 32'h0);
    flush = 1'b0;
    vectors++; if (hi1 !== 32'd0) begin miscompares++; $display("FAIL flush_priority: hi=%h want 0", hi1); end
  endtask

`ifdef MUL_ACC_EN
  task automatic test_accumulate();
    issue1(3'b010, 32'h0, 32'h0);
    issue1(3'b011, 32'hFFFFFFFF, 32'h0);
    issue1(3'b101, 32'd1, 32'd1);
    tick();
    tick();
    vectors++; if ({hi1, lo1} !== 64'h00000001_00000000) begin miscompares++; $display("FAIL maddu: got %h want 0000000100000000", {hi1, lo1}); end
    issue1(3'b110, 32'd1, 32'd2);
    vectors++; if (s1 !== 1'b1) begin miscompares++; $display("FAIL msub_signed: got %b want 1", s1); end
    tick();
    tick();
    vectors++; if ({hi1, lo1} !== 64'h00000000_FFFFFFFE) begin miscompares++; $display("FAIL msub: got %h want 00000000fffffffe", {hi1, lo1}); end
  endtask
`else
  task automatic test_accumulate();
    issue1(3'b101, 32'd1, 32'd1);
    vectors++; if (busy1 !== 1'b0 || if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL acc_noop_idle: busy=%b ready=%b want 0 1", busy1, if1.req_ready); end
    tick();
    tick();
    vectors++; if ({hi1, lo1} !== 64'd6) begin miscompares++; $display("FAIL acc_noop_hilo: got %h want 6", {hi1, lo1}); end
  endtask
`endif

  task automatic test_back_to_back();
    if3.req_valid = 1'b1;
    if3.req_op    = 3'b000;
    if3.req_src1  = 32'd3;
    if3.req_src2  = 32'd4;
    tick();
    if3.req_src1  = 32'd5;
    if3.req_src2  = 32'd6;
    repeat (3) tick();
    vectors++; if (lo3 !== 32'd0 || if3.req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_first_early: lo=%h ready=%b want 0 0", lo3, if3.req_ready); end
    tick();
    vectors++; if (lo3 !== 32'd12 || if3.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_first: lo=%h ready=%b want c 1", lo3, if3.req_ready); end
    tick();
    if3.req_valid = 1'b0;
    vectors++; if (busy3 !== 1'b1 || x3 !== 32'd5) begin miscompares++; $display("FAIL b2b_second_accept: busy=%b x=%h want 1 5", busy3, x3); end
    repeat (3) tick();
    vectors++; if (lo3 !== 32'd12) begin miscompares++; $display("FAIL b2b_second_early: lo=%h want c", lo3); end
    tick();
    vectors++; if ({hi3, lo3} !== 64'd30) begin miscompares++; $display("FAIL b2b_second: got %h want 1e", {hi3, lo3}); end
  endtask

  task automatic test_flush_calc_and_reset();
    if3.req_valid = 1'b1;
    if3.req_op    = 3'b001;
    if3.req_src1  = 32'd9;
    if3.req_src2  = 32'd9;
    tick();
    if3.req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL flush_calc_busy: got %b want 0", busy3); end
    repeat (4) tick();
    vectors++; if (lo3 !== 32'd30) begin miscompares++; $display("FAIL flush_calc_hilo: lo=%h want 1e", lo3); end
    if3.req_valid = 1'b1;
    if3.req_op    = 3'b000;
    if3.req_src1  = 32'd7;
    if3.req_src2  = 32'd8;
    tick();
    if3.req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    vectors++; if ({hi3, lo3, x3} !== 96'd0 || busy3 !== 1'b0 || if3.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid: hilo=%h x=%h busy=%b ready=%b", {hi3, lo3}, x3, busy3, if3.req_ready); end
    reset = 1'b0;
    repeat (3) tick();
    vectors++; if ({hi3, lo3} !== 64'd0) begin miscompares++; $display("FAIL reset_no_write: got %h want 0", {hi3, lo3}); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    if1.req_valid = 1'b0; if1.req_op = 3'b0; if1.req_src1 = 32'd0; if1.req_src2 = 32'd0;
    if3.req_valid = 1'b0; if3.req_op = 3'b0; if3.req_src1 = 32'd0; if3.req_src2 = 32'd0;
    test_reset();
    test_mthi_mtlo();
    test_mult_signed();
    test_multu();
    test_flush();
    test_accumulate();
    test_back_to_back();
    test_flush_calc_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
